// File: rtl/axi4lite_pkg.sv
// rtl/axi4lite_pkg.sv - shared constants and state encoding for the AXI4-Lite master
package axi4lite_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;
  localparam logic [1:0] MODE_RW   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_e;

endpackage

// File: rtl/axi4lite_timeout_cnt.sv
// rtl/axi4lite_timeout_cnt.sv - response-wait watchdog; expired flags the last allowed cycle
module axi4lite_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] count;

      // Saturates at LAST so a stalled FSM can never wrap past expiry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && count != LAST) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/axi4lite_master_ctrl.sv
// rtl/axi4lite_master_ctrl.sv - single-outstanding AXI4-Lite master with RD/WR/RW modes and timeout
module axi4lite_master_ctrl
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  iClock,
  input  logic                  iResetN,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic [1:0]            iReqMode,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqData,
  input  logic [STRB_WIDTH-1:0] iReqStrb,
  output logic                  oRspValid,
  input  logic                  iRspReady,
  output logic [DATA_WIDTH-1:0] oRspData,
  output logic [1:0]            oRspResp,
  output logic                  oRspTimeout,
  output logic                  pAXI4_ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_bits_addr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_bits_data,
  input  logic [1:0]            r_bits_resp,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_WIDTH-1:0] aw_bits_addr,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_bits_data,
  output logic [STRB_WIDTH-1:0] w_bits_strb,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_bits_resp
);

  state_e                state, next_state;
  logic                  accept;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  tmo_enable, tmo_expired;

  assign ar_bits_addr = addr_q;
  assign aw_bits_addr = addr_q;
  assign w_bits_data  = data_q;
  assign w_bits_strb  = strb_q;

  assign tmo_enable = (state == ST_WR_RESP) || (state == ST_RD_DATA);

  axi4lite_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (iClock),
    .rst_n  (iResetN),
    .clear  (!tmo_enable),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Ready/valid outputs are held for the whole state, so a handshake is just the peer's signal.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (oReqReady && iReqValid && iReqMode != MODE_NONE) begin
          accept     = 1'b1;
          next_state = (iReqMode == MODE_RD) ? ST_RD_ADDR : ST_WR_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if ((!aw_valid || aw_ready) && (!w_valid || w_ready)) next_state = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (b_valid) begin
          next_state = (mode_q == MODE_RW && b_bits_resp == RESP_OKAY) ? ST_RD_ADDR : ST_RSP;
        end else if (tmo_expired) begin
          next_state = ST_RSP;
        end
      end
      ST_RD_ADDR: if (ar_ready) next_state = ST_RD_DATA;
      ST_RD_DATA: if (r_valid || tmo_expired) next_state = ST_RSP;
      ST_RSP:     if (iRspReady) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oReqReady      <= 1'b0;
      pAXI4_ar_valid <= 1'b0;
      r_ready        <= 1'b0;
      b_ready        <= 1'b0;
      aw_valid       <= 1'b0;
      w_valid        <= 1'b0;
      oRspValid      <= 1'b0;
      oRspData       <= '0;
      oRspResp       <= RESP_OKAY;
      oRspTimeout    <= 1'b0;
      mode_q         <= MODE_NONE;
      addr_q         <= '0;
      data_q         <= '0;
      strb_q         <= '0;
    end else begin
      oReqReady      <= (next_state == ST_IDLE);
      pAXI4_ar_valid <= (next_state == ST_RD_ADDR);
      r_ready        <= (next_state == ST_RD_DATA);
      b_ready        <= (next_state == ST_WR_RESP);
      oRspValid      <= (next_state == ST_RSP);

      if (accept) begin
        mode_q      <= iReqMode;
        addr_q      <= iReqAddr;
        data_q      <= iReqData;
        strb_q      <= iReqStrb;
        aw_valid    <= (iReqMode != MODE_RD);
        w_valid     <= (iReqMode != MODE_RD);
        oRspData    <= '0;
        oRspResp    <= RESP_OKAY;
        oRspTimeout <= 1'b0;
      end else begin
        if (aw_valid && aw_ready) aw_valid <= 1'b0;
        if (w_valid && w_ready)   w_valid  <= 1'b0;
      end

      // A real B/R in the expiry cycle takes priority over the abort.
      if ((state == ST_WR_RESP && b_valid) || (state == ST_RD_DATA && r_valid)) begin
        oRspResp <= (state == ST_WR_RESP) ? b_bits_resp : r_bits_resp;
        if (state == ST_RD_DATA) oRspData <= r_bits_data;
      end else if (tmo_enable && tmo_expired) begin
        oRspResp    <= RESP_SLVERR;
        oRspData    <= '0;
        oRspTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// tb/tb_axi4lite_master_ctrl.sv - scoreboard bench for axi4lite_master_ctrl with a behavioural slave
module tb_axi4lite_master_ctrl;
  import axi4lite_pkg::*;

  logic        iClock = 1'b0;
  logic        iResetN = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic [1:0]  iReqMode = 2'b00;
  logic [31:0] iReqAddr = '0;
  logic [31:0] iReqData = '0;
  logic [3:0]  iReqStrb = '0;
  logic        oRspValid;
  logic        iRspReady = 1'b1;
  logic [31:0] oRspData;
  logic [1:0]  oRspResp;
  logic        oRspTimeout;
  logic        pAXI4_ar_valid, ar_ready = 1'b0;
  logic [31:0] ar_bits_addr;
  logic        r_valid = 1'b0, r_ready;
  logic [31:0] r_bits_data = '0;
  logic [1:0]  r_bits_resp = '0;
  logic        aw_valid, aw_ready = 1'b0;
  logic [31:0] aw_bits_addr;
  logic        w_valid, w_ready = 1'b0;
  logic [31:0] w_bits_data;
  logic [3:0]  w_bits_strb;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_bits_resp = '0;

  axi4lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .iClock(iClock), .iResetN(iResetN), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqMode(iReqMode), .iReqAddr(iReqAddr), .iReqData(iReqData), .iReqStrb(iReqStrb),
    .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspData(oRspData), .oRspResp(oRspResp),
    .oRspTimeout(oRspTimeout), .pAXI4_ar_valid(pAXI4_ar_valid), .ar_ready(ar_ready),
    .ar_bits_addr(ar_bits_addr), .r_valid(r_valid), .r_ready(r_ready), .r_bits_data(r_bits_data),
    .r_bits_resp(r_bits_resp), .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_bits_addr(aw_bits_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_bits_data(w_bits_data), .w_bits_strb(w_bits_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_bits_resp(b_bits_resp)
  );

  always #5 iClock = ~iClock;

  int cyc = 0;
  always @(posedge iClock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        tmo;
    int          n;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs = 0;
  int   rsp_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave configuration and observation
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
  logic [31:0] r_data_cfg = '0;
  bit          r_enable = 1'b1;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, b_issued = 0, r_issued = 0;
  bit          f_aw = 0, f_w = 0, f_ar = 0, f_b = 0, f_r = 0;
  logic [31:0] seen_aw_addr = '0, seen_ar_addr = '0, seen_w_data = '0;
  logic [3:0]  seen_w_strb = '0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;

  // Drives on the falling edge; f_* flags predict the handshake at the next rising edge.
  initial begin
    forever begin
      @(negedge iClock);
      if (f_aw) aw_hs++;
      if (f_w)  w_hs++;
      if (f_ar) ar_hs++;
      if (f_b) begin b_valid = 1'b0; b_hs++; end
      if (f_r) r_valid = 1'b0;
      aw_ready = aw_valid && (aw_cnt >= aw_delay);
      aw_cnt   = aw_valid ? aw_cnt + 1 : 0;
      w_ready  = w_valid && (w_cnt >= w_delay);
      w_cnt    = w_valid ? w_cnt + 1 : 0;
      ar_ready = pAXI4_ar_valid;
      if (!b_valid && aw_hs > b_issued && w_hs > b_issued) begin
        b_valid = 1'b1; b_bits_resp = b_resp_cfg; b_issued++;
      end
      if (!r_valid && r_enable && ar_hs > r_issued) begin
        r_valid = 1'b1; r_bits_data = r_data_cfg; r_bits_resp = r_resp_cfg; r_issued++;
      end
      f_aw = aw_valid && aw_ready;
      f_w  = w_valid && w_ready;
      f_ar = pAXI4_ar_valid && ar_ready;
      f_b  = b_valid && b_ready;
      f_r  = r_valid && r_ready;
      if (f_aw) begin seen_aw_addr = aw_bits_addr; aw_hs_cyc = cyc; end
      if (f_w)  begin seen_w_data = w_bits_data; seen_w_strb = w_bits_strb; w_hs_cyc = cyc; end
      if (f_ar) seen_ar_addr = ar_bits_addr;
    end
  end

  logic prev_v = 1'b0;
  int   first_cyc = 0;
  exp_t e_mon;

  initial begin
    forever begin
      @(negedge iClock);
      if (oRspValid && !prev_v) first_cyc = cyc;
      prev_v = oRspValid && !iRspReady;
      if (oRspValid && iRspReady) begin
        if (sb.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_rsp: response data 0x%0h resp %0d arrived, none expected", oRspData, oRspResp);
        end else begin
          e_mon = sb.pop_front();
          chk("rsp_data", 64'(oRspData), 64'(e_mon.data));
          chk("rsp_resp", 64'(oRspResp), 64'(e_mon.resp));
          chk("rsp_timeout", 64'(oRspTimeout), 64'(e_mon.tmo));
          chk("rsp_latency", 64'(first_cyc - e_mon.n), 64'(e_mon.lat));
        end
        rsp_seen++;
      end
    end
  end

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic send(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit push, input logic [31:0] ed,
                      input logic [1:0] er, input logic et, input int lat, output int n);
    int k;
    exp_t e;
    iReqValid = 1'b1; iReqMode = mode; iReqAddr = addr; iReqData = data; iReqStrb = strb;
    k = 0;
    while (!oReqReady && k < 50) begin step(); k++; end
    chk("req_ready", 64'(oReqReady), 64'(1));
    n = cyc;
    if (push) begin
      e.data = ed; e.resp = er; e.tmo = et; e.n = n; e.lat = lat;
      sb.push_back(e);
    end
    step();
    iReqValid = 1'b0; iReqMode = ~mode; iReqAddr = ~addr; iReqData = ~data; iReqStrb = ~strb;
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (rsp_seen < target && k < 60) begin step(); k++; end
    chk("rsp_arrived", 64'(rsp_seen >= target), 64'(1));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ar0, b0;
    repeat (2) step();
    chk("rst_req_ready", 64'(oReqReady), 64'(0));
    chk("rst_valids", 64'({pAXI4_ar_valid, aw_valid, w_valid, oRspValid, r_ready, b_ready}), 64'(0));
    chk("rst_rsp", 64'({oRspData, oRspResp, oRspTimeout}), 64'(0));
    iResetN = 1'b1;
    step();
    chk("post_rst_ready", 64'(oReqReady), 64'(1));

    iReqValid = 1'b1; iReqMode = 2'b00; iReqAddr = 32'h0000_0500;
    repeat (3) step();
    chk("mode00_ready", 64'(oReqReady), 64'(1));
    chk("mode00_idle", 64'({pAXI4_ar_valid, aw_valid, w_valid}), 64'(0));
    iReqValid = 1'b0;

    r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = RESP_OKAY;
    send(MODE_RD, 32'h8000_0010, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, RESP_OKAY, 1'b0, 3, n);
    chk("rd_ar_valid_n1", 64'(pAXI4_ar_valid), 64'(1));
    chk("rd_ar_addr", 64'(ar_bits_addr), 64'h8000_0010);
    chk("rd_busy_ready", 64'(oReqReady), 64'(0));
    wait_rsp(1);

    aw_delay = 3; b_resp_cfg = RESP_OKAY; b0 = b_hs;
    send(MODE_WR, 32'h0000_0100, 32'h1234_5678, 4'h3, 1, 32'h0, RESP_OKAY, 1'b0, 6, n);
    step();
    chk("wr_w_drops_first", 64'({aw_valid, w_valid}), 64'(2'b10));
    wait_rsp(2);
    chk("wr_aw_addr", 64'(seen_aw_addr), 64'h0000_0100);
    chk("wr_w_data", 64'(seen_w_data), 64'h1234_5678);
    chk("wr_w_strb", 64'(seen_w_strb), 64'h3);
    chk("wr_w_cycle", 64'(w_hs_cyc - n), 64'(1));
    chk("wr_aw_skew", 64'(aw_hs_cyc - w_hs_cyc), 64'(3));
    chk("wr_single_b", 64'(b_hs - b0), 64'(1));
    aw_delay = 0;

    b_resp_cfg = RESP_SLVERR; ar0 = ar_hs;
    send(MODE_RW, 32'h2000_0000, 32'hCAFE_F00D, 4'hF, 1, 32'h0, RESP_SLVERR, 1'b0, 3, n);
    wait_rsp(3);
    chk("rwerr_no_ar", 64'(ar_hs - ar0), 64'(0));

    b_resp_cfg = RESP_OKAY; r_data_cfg = 32'h0000_00A5; r_resp_cfg = RESP_DECERR;
    iRspReady = 1'b0;
    send(MODE_RW, 32'h2000_0040, 32'h0000_005A, 4'h1, 1, 32'h0000_00A5, RESP_DECERR, 1'b0, 5, n);
    repeat (5) step();
    chk("rw_hold_valid", 64'(oRspValid), 64'(1));
    chk("rw_busy_ready", 64'(oReqReady), 64'(0));
    step();
    iRspReady = 1'b1;
    wait_rsp(4);
    chk("rw_ar_addr", 64'(seen_ar_addr), 64'h2000_0040);
    chk("rw_w_data", 64'(seen_w_data), 64'h0000_005A);

    r_enable = 1'b0;
    send(MODE_RD, 32'h3000_0000, 32'h0, 4'h0, 1, 32'h0, RESP_SLVERR, 1'b1, 10, n);
    wait_rsp(5);
    r_issued = ar_hs;
    r_valid = 1'b1; r_bits_data = 32'h1111_2222; r_bits_resp = RESP_OKAY;
    chk("late_r_ready", 64'(r_ready), 64'(0));
    step();
    r_valid = 1'b0;
    repeat (3) step();
    chk("late_r_no_rsp", 64'(oRspValid), 64'(0));
    chk("late_r_idle", 64'(oReqReady), 64'(1));
    r_enable = 1'b1;

    aw_delay = 100; w_delay = 100;
    send(MODE_WR, 32'h0000_0400, 32'h0000_0077, 4'hF, 0, 32'h0, RESP_OKAY, 1'b0, 0, n);
    chk("mid_aw_valid", 64'(aw_valid), 64'(1));
    step();
    iResetN = 1'b0;
    #1;
    chk("mid_rst_valids", 64'({pAXI4_ar_valid, aw_valid, w_valid, oRspValid, r_ready, b_ready}), 64'(0));
    chk("mid_rst_ready", 64'(oReqReady), 64'(0));
    step();
    iResetN = 1'b1; aw_delay = 0; w_delay = 0;
    step();
    chk("mid_post_ready", 64'(oReqReady), 64'(1));
    r_data_cfg = 32'h0BAD_F00D; r_resp_cfg = RESP_OKAY;
    send(MODE_RD, 32'h8000_0020, 32'h0, 4'h0, 1, 32'h0BAD_F00D, RESP_OKAY, 1'b0, 3, n);
    wait_rsp(6);
    chk("post_rst_ar_addr", 64'(seen_ar_addr), 64'h8000_0020);

    repeat (3) step();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
